ex_issue_stage: RTL and testbench



---
 rtl/ex_issue_stage_pkg.sv | 50 +++++
 rtl/ex_issue_stage_alu_ctrl_decode.sv | 64 ++++++
 rtl/ex_issue_stage.sv | 160 ++++++++++++++++
 tb/tb_ex_issue_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_stage_pkg.sv
// Shared definitions for the ID/EX issue stage: datapath width, ALU control
// codes, RV32I major opcodes, operand-select encodings and the funct3 -> ALU map.
// No ports; imported by alu_ctrl_decode and ex_issue_stage.
package ex_issue_stage_pkg;

  localparam int XLEN = 32;

  // ALU control codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} srca_sel_e;
  typedef enum logic       {SRCB_RS2, SRCB_IMM}           srcb_sel_e;

  // Shift funct3 values (001/101) are not supported by this ALU.
  function automatic logic f3_is_shift(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  // Arithmetic/logic funct3 mapping shared by R-type and I-ALU.
  function automatic logic [2:0] f3_to_alu(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b100:  return ALU_XOR;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ex_issue_stage_alu_ctrl_decode.sv
// alu_ctrl_decode: maps opcode/funct3/funct7b5 to ALU control, operand selects
// and instruction class flags. Purely combinational (0 cycles), no backpressure.
// Ports: i_opcode/i_funct3/i_funct7b5 in; o_alu_ctrl, o_srca_sel, o_srcb_sel,
// o_reg_write (before rd!=0 gating), o_branch, o_illegal out.
module alu_ctrl_decode
  import ex_issue_stage_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_ctrl,
  output srca_sel_e  o_srca_sel,
  output srcb_sel_e  o_srcb_sel,
  output logic       o_reg_write,
  output logic       o_branch,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctrl  = ALU_ADD;
    o_srca_sel  = SRCA_RS1;
    o_srcb_sel  = SRCB_RS2;
    o_reg_write = 1'b0;
    o_branch    = 1'b0;
    o_illegal   = 1'b0;
    case (i_opcode)
      OP_R, OP_IMM: begin
        o_srcb_sel = (i_opcode == OP_IMM) ? SRCB_IMM : SRCB_RS2;
        if (f3_is_shift(i_funct3)) begin
          o_illegal = 1'b1;
        end else begin
          // funct7b5 selects sub only for register-register ops
          o_alu_ctrl  = f3_to_alu(i_funct3, (i_opcode == OP_R) && i_funct7b5);
          o_reg_write = 1'b1;
        end
      end
      OP_LOAD, OP_STORE: begin
        o_srcb_sel  = SRCB_IMM;
        o_reg_write = (i_opcode == OP_LOAD);
      end
      OP_BRANCH: begin
        o_alu_ctrl = ALU_SUB;
        o_branch   = 1'b1;
      end
      OP_LUI: begin
        o_alu_ctrl  = ALU_PASS;
        o_srca_sel  = SRCA_ZERO;
        o_srcb_sel  = SRCB_IMM;
        o_reg_write = 1'b1;
      end
      OP_AUIPC, OP_JAL: begin
        o_srca_sel  = SRCA_PC;
        o_srcb_sel  = SRCB_IMM;
        o_reg_write = 1'b1;
      end
      OP_JALR: begin
        o_srcb_sel  = SRCB_IMM;
        o_reg_write = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ex_issue_stage: ID/EX register feeding the ALU (decode, forwarding, operand select).
// Latency 1 cycle, all outputs registered. Backpressure: in_ready = !stall; stall holds, flush bubbles.
// Ports: clk/rst (sync, active-high); in_* decoded fields from ID; stall/flush from hazard unit;
// fwd_exm_*/fwd_mwb_* writeback bypass sources; SrcA/SrcB/ALUControl and out_* to EX.
// Build option: define FWD_BYPASS_EN to enable EX/MEM and MEM/WB operand forwarding;
// otherwise the fwd_* ports are ignored and operands come from the register file only.
module ex_issue_stage #(
  parameter int XLEN = ex_issue_stage_pkg::XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [6:0]             in_opcode,
  input  logic [2:0]             in_funct3,
  input  logic                   in_funct7b5,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [4:0]             in_rd,
  input  logic [XLEN-1:0]        in_rs1_val,
  input  logic [XLEN-1:0]        in_rs2_val,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   fwd_exm_we,
  input  logic [4:0]             fwd_exm_rd,
  input  logic [XLEN-1:0]        fwd_exm_val,
  input  logic                   fwd_mwb_we,
  input  logic [4:0]             fwd_mwb_rd,
  input  logic [XLEN-1:0]        fwd_mwb_val,
  output logic signed [XLEN-1:0] SrcA,
  output logic signed [XLEN-1:0] SrcB,
  output logic [2:0]             ALUControl,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_rs2_val,
  output logic [4:0]             out_rd,
  output logic                   out_reg_write,
  output logic                   out_branch,
  output logic [2:0]             out_funct3,
  output logic                   out_illegal
);
  import ex_issue_stage_pkg::*;

  logic [2:0]      w_alu_ctrl;
  srca_sel_e       w_srca_sel;
  srcb_sel_e       w_srcb_sel;
  logic            w_reg_write;
  logic            w_branch;
  logic            w_illegal;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;
  logic [XLEN-1:0] w_srca;
  logic [XLEN-1:0] w_srcb;

  logic [XLEN-1:0] r_srca;
  logic [XLEN-1:0] r_srcb;
  logic [2:0]      r_alu_ctrl;
  logic            r_valid;
  logic [XLEN-1:0] r_rs2_val;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_branch;
  logic [2:0]      r_funct3;
  logic            r_illegal;

  alu_ctrl_decode u_dec (
    .i_opcode    (in_opcode),
    .i_funct3    (in_funct3),
    .i_funct7b5  (in_funct7b5),
    .o_alu_ctrl  (w_alu_ctrl),
    .o_srca_sel  (w_srca_sel),
    .o_srcb_sel  (w_srcb_sel),
    .o_reg_write (w_reg_write),
    .o_branch    (w_branch),
    .o_illegal   (w_illegal)
  );

`ifdef FWD_BYPASS_EN
  // EX/MEM is younger than MEM/WB, so it wins; x0 is never bypassed.
  always_comb begin
    w_rs1_fwd = in_rs1_val;
    if (fwd_exm_we && (fwd_exm_rd == in_rs1) && (in_rs1 != 5'd0))
      w_rs1_fwd = fwd_exm_val;
    else if (fwd_mwb_we && (fwd_mwb_rd == in_rs1) && (in_rs1 != 5'd0))
      w_rs1_fwd = fwd_mwb_val;
  end

  always_comb begin
    w_rs2_fwd = in_rs2_val;
    if (fwd_exm_we && (fwd_exm_rd == in_rs2) && (in_rs2 != 5'd0))
      w_rs2_fwd = fwd_exm_val;
    else if (fwd_mwb_we && (fwd_mwb_rd == in_rs2) && (in_rs2 != 5'd0))
      w_rs2_fwd = fwd_mwb_val;
  end
`else
  // Hazard unit stalls instead of bypassing; the bypass inputs are intentionally unused.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_exm_we, fwd_exm_rd, fwd_exm_val,
                          fwd_mwb_we, fwd_mwb_rd, fwd_mwb_val, in_rs1, in_rs2};
  assign w_rs1_fwd = in_rs1_val;
  assign w_rs2_fwd = in_rs2_val;
`endif

  always_comb begin
    case (w_srca_sel)
      SRCA_PC:   w_srca = in_pc;
      SRCA_ZERO: w_srca = '0;
      default:   w_srca = w_rs1_fwd;
    endcase
  end

  assign w_srcb = (w_srcb_sel == SRCB_IMM) ? in_imm : w_rs2_fwd;

  // Priority: rst > flush > stall > capture. Flush clears only the control
  // bits; data fields are don't-care behind out_valid=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_srca      <= '0;
      r_srcb      <= '0;
      r_alu_ctrl  <= ALU_ADD;
      r_valid     <= 1'b0;
      r_rs2_val   <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
      r_funct3    <= '0;
      r_illegal   <= 1'b0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!stall) begin
      r_srca      <= w_srca;
      r_srcb      <= w_srcb;
      r_alu_ctrl  <= w_alu_ctrl;
      r_valid     <= in_valid;
      r_rs2_val   <= w_rs2_fwd;
      r_rd        <= in_rd;
      r_reg_write <= in_valid && w_reg_write && (in_rd != 5'd0);
      r_branch    <= in_valid && w_branch;
      r_funct3    <= in_funct3;
      r_illegal   <= in_valid && w_illegal;
    end
  end

  assign in_ready      = !stall;
  assign SrcA          = r_srca;
  assign SrcB          = r_srcb;
  assign ALUControl    = r_alu_ctrl;
  assign out_valid     = r_valid;
  assign out_rs2_val   = r_rs2_val;
  assign out_rd        = r_rd;
  assign out_reg_write = r_reg_write;
  assign out_branch    = r_branch;
  assign out_funct3    = r_funct3;
  assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Testbench for ex_issue_stage: directed vectors, expected outputs queued at
// stimulus time and popped/compared by an independent monitor each cycle.
module tb_ex_issue_stage;

`ifdef FWD_BYPASS_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic        stall, flush;
  logic        fwd_exm_we, fwd_mwb_we;
  logic [4:0]  fwd_exm_rd, fwd_mwb_rd;
  logic [31:0] fwd_exm_val, fwd_mwb_val;
  logic signed [31:0] SrcA, SrcB;
  logic [2:0]  ALUControl;
  logic        out_valid;
  logic [31:0] out_rs2_val;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_branch, out_illegal;
  logic [2:0]  out_funct3;

  ex_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
    .stall(stall), .flush(flush),
    .fwd_exm_we(fwd_exm_we), .fwd_exm_rd(fwd_exm_rd), .fwd_exm_val(fwd_exm_val),
    .fwd_mwb_we(fwd_mwb_we), .fwd_mwb_rd(fwd_mwb_rd), .fwd_mwb_val(fwd_mwb_val),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_rs2_val(out_rs2_val), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_branch(out_branch), .out_funct3(out_funct3), .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        rdy, valid;
    logic [2:0]  alu;
    logic [31:0] a, b, rs2v;
    logic [4:0]  rd;
    logic        rw, br, ill;
    logic [2:0]  f3;
    bit          chk_a, chk_b, chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input string nm, input logic rdy, input logic valid,
                              input logic [2:0] alu, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] rs2v,
                              input logic [4:0] rd, input logic rw, input logic br,
                              input logic [2:0] f3, input logic ill);
    exp_t e;
    e.name = nm; e.rdy = rdy; e.valid = valid; e.alu = alu; e.a = a; e.b = b;
    e.rs2v = rs2v; e.rd = rd; e.rw = rw; e.br = br; e.f3 = f3; e.ill = ill;
    e.chk_a = 1'b1; e.chk_b = 1'b1; e.chk_data = 1'b1;
    return e;
  endfunction

  task automatic check(input string vec, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", vec, fld, act, req);
    end
  endtask

  // Monitor: outputs settle just after each rising edge; compare against the
  // expectation queued at the preceding falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "in_ready", 32'(in_ready), 32'(e.rdy));
        check(e.name, "out_valid", 32'(out_valid), 32'(e.valid));
        check(e.name, "out_reg_write", 32'(out_reg_write), 32'(e.rw));
        check(e.name, "out_branch", 32'(out_branch), 32'(e.br));
        check(e.name, "out_illegal", 32'(out_illegal), 32'(e.ill));
        if (e.chk_data) begin
          check(e.name, "ALUControl", 32'(ALUControl), 32'(e.alu));
          if (e.chk_a) check(e.name, "SrcA", SrcA, e.a);
          if (e.chk_b) check(e.name, "SrcB", SrcB, e.b);
          check(e.name, "out_rs2_val", out_rs2_val, e.rs2v);
          check(e.name, "out_rd", 32'(out_rd), 32'(e.rd));
          check(e.name, "out_funct3", 32'(out_funct3), 32'(e.f3));
        end
      end
    end
  end

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc);
    in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rs1_val = v1; in_rs2_val = v2; in_imm = imm; in_pc = pc;
  endtask

  task automatic ctl(input logic v, input logic st, input logic fl, input logic rs);
    in_valid = v; stall = st; flush = fl; rst = rs;
  endtask

  task automatic fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ev,
                     input logic mw, input logic [4:0] mrd, input logic [31:0] mv);
    fwd_exm_we = ew; fwd_exm_rd = erd; fwd_exm_val = ev;
    fwd_mwb_we = mw; fwd_mwb_rd = mrd; fwd_mwb_val = mv;
  endtask

  task automatic push(input exp_t e);
    sb.push_back(e);
    last = e;
  endtask

  initial begin
    exp_t e;
    ctl(1'b0, 1'b0, 1'b0, 1'b1);
    fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    instr(7'b0, 3'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Reset with a valid instruction present: everything reads zero
    @(negedge clk);
    instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'd0);
    ctl(1'b1, 1'b0, 1'b0, 1'b1);
    push(mk("reset", 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));

    // R-type sub 10 - 3
    @(negedge clk);
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    push(mk("r_sub", 1, 1, 3'b001, 10, 3, 3, 3, 1, 0, 3'b000, 0));

    // AUIPC: pc + imm
    @(negedge clk);
    instr(7'b0010111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'h2000, 32'h100);
    push(mk("auipc", 1, 1, 3'b000, 32'h100, 32'h2000, 0, 4, 1, 0, 3'b000, 0));

    // LUI: pass imm through SrcB
    @(negedge clk);
    instr(7'b0110111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0, 32'h5000, 32'h104);
    e = mk("lui", 1, 1, 3'b100, 0, 32'h5000, 0, 5, 1, 0, 3'b000, 0);
    e.chk_a = 1'b0;
    push(e);

    // Forward priority: both stages write x5, EX/MEM wins
    @(negedge clk);
    instr(7'b0110011, 3'b000, 1'b0, 5'd5, 5'd6, 5'd7, 32'd100, 32'd1, 32'd0, 32'd0);
    fwd(1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9);
    push(mk("fwd_prio", 1, 1, 3'b000, FWD ? 32'd7 : 32'd100, 1, 1, 7, 1, 0, 3'b000, 0));

    // Only MEM/WB matches rs1
    @(negedge clk);
    instr(7'b0110011, 3'b000, 1'b0, 5'd9, 5'd6, 5'd7, 32'd100, 32'd1, 32'd0, 32'd0);
    fwd(1'b1, 5'd5, 32'd7, 1'b1, 5'd9, 32'd9);
    push(mk("fwd_mwb", 1, 1, 3'b000, FWD ? 32'd9 : 32'd100, 1, 1, 7, 1, 0, 3'b000, 0));

    // x0 is never forwarded, R-type or
    @(negedge clk);
    instr(7'b0110011, 3'b110, 1'b0, 5'd0, 5'd0, 5'd8, 32'd55, 32'd66, 32'd0, 32'd0);
    fwd(1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd9);
    push(mk("fwd_x0", 1, 1, 3'b011, 55, 66, 66, 8, 1, 0, 3'b110, 0));

    // rs2 forwarding feeds both SrcB and out_rs2_val, R-type and
    @(negedge clk);
    instr(7'b0110011, 3'b111, 1'b0, 5'd1, 5'd12, 5'd8, 32'd4, 32'd5, 32'd0, 32'd0);
    fwd(1'b1, 5'd12, 32'h77, 1'b0, 5'd12, 32'h99);
    push(mk("fwd_rs2", 1, 1, 3'b010, 4, FWD ? 32'h77 : 32'd5, FWD ? 32'h77 : 32'd5,
            8, 1, 0, 3'b111, 0));

    // xori to x0: no register write
    @(negedge clk);
    fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    instr(7'b0010011, 3'b100, 1'b0, 5'd1, 5'd0, 5'd0, 32'hF0, 32'd0, 32'hFF, 32'd0);
    push(mk("xori_x0", 1, 1, 3'b111, 32'hF0, 32'hFF, 0, 0, 0, 0, 3'b100, 0));

    // bne: sub, branch flag, funct3 001 is legal here
    @(negedge clk);
    instr(7'b1100011, 3'b001, 1'b0, 5'd1, 5'd2, 5'd9, 32'd20, 32'd21, 32'd0, 32'd0);
    push(mk("branch", 1, 1, 3'b001, 20, 21, 21, 9, 0, 1, 3'b001, 0));

    // load word
    @(negedge clk);
    instr(7'b0000011, 3'b010, 1'b0, 5'd2, 5'd0, 5'd10, 32'h1000, 32'd0, 32'd8, 32'd0);
    push(mk("load", 1, 1, 3'b000, 32'h1000, 8, 0, 10, 1, 0, 3'b010, 0));

    // Stall two cycles while inputs change: outputs hold, in_ready low
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      instr(7'b0110011, 3'b000, 1'b1, 5'd3, 5'd4, 5'd11, 32'd77 + 32'(i), 32'd88, 32'd0, 32'd0);
      ctl(1'b1, 1'b1, 1'b0, 1'b0);
      e = last;
      e.name = (i == 0) ? "stall1" : "stall2";
      e.rdy = 1'b0;
      push(e);
    end

    // Stall + flush: flush wins
    @(negedge clk);
    ctl(1'b1, 1'b1, 1'b1, 1'b0);
    e = mk("stall_flush", 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    e.chk_data = 1'b0;
    push(e);

    // slli: shift is illegal
    @(negedge clk);
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    instr(7'b0010011, 3'b001, 1'b0, 5'd1, 5'd0, 5'd7, 32'd3, 32'd0, 32'd2, 32'd0);
    e = mk("slli", 1, 1, 3'b000, 0, 0, 0, 7, 0, 0, 3'b001, 1);
    e.chk_a = 1'b0; e.chk_b = 1'b0;
    push(e);

    // Bubble: fields captured, flags zero
    @(negedge clk);
    ctl(1'b0, 1'b0, 1'b0, 1'b0);
    instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'd0, 32'd0);
    push(mk("bubble", 1, 0, 3'b001, 10, 3, 3, 3, 0, 0, 3'b000, 0));

    // Flush alone on a valid branch
    @(negedge clk);
    ctl(1'b1, 1'b0, 1'b1, 1'b0);
    instr(7'b1100011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd5, 32'd5, 32'd0, 32'd0);
    e = mk("flush", 1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    e.chk_data = 1'b0;
    push(e);

    // Reset wins over stall and flush
    @(negedge clk);
    ctl(1'b1, 1'b1, 1'b1, 1'b1);
    push(mk("rst_prio", 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0));

    // Unknown opcode is illegal
    @(negedge clk);
    ctl(1'b1, 1'b0, 1'b0, 1'b0);
    instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd4, 32'd1, 32'd2, 32'd0, 32'd0);
    e = mk("bad_op", 1, 1, 3'b000, 0, 0, 2, 4, 0, 0, 3'b000, 1);
    e.chk_a = 1'b0; e.chk_b = 1'b0;
    push(e);

    // JAL: pc + imm, writes ra
    @(negedge clk);
    instr(7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'h10, 32'h200);
    push(mk("jal", 1, 1, 3'b000, 32'h200, 32'h10, 0, 1, 1, 0, 3'b000, 0));

    @(negedge clk);
    ctl(1'b0, 1'b0, 1'b0, 1'b0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
